// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   function automatic int grant_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // One extra bit so the counter can hold MAX_BURST itself without wrapping.
   function automatic int cnt_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted request strictly after last_grant,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = grant_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GRANT_W-1:0] last_grant,
   output logic               any,
   output logic [GRANT_W-1:0] grant
);

   // Scan offsets 1..NUM_REQ so the previous owner is considered last.
   always_comb begin
      int idx_s;
      any   = 1'b0;
      grant = '0;
      idx_s = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx_s = (int'(last_grant) + off) % NUM_REQ;
         if (!any && req[idx_s]) begin
            any   = 1'b1;
            grant = GRANT_W'(idx_s);
         end else begin
            any   = any;
            grant = grant;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// The accepted word is forwarded combinationally to the FIFO in the same cycle.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int MAX_BURST = 4,
   localparam int GRANT_W   = grant_width(NUM_REQ),
   localparam int CNT_W     = cnt_width(MAX_BURST)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_last,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_W-1:0]         fifo_wr_data,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      busy
);

   arb_state_e         state_r;
   arb_state_e         state_nx_s;
   logic [GRANT_W-1:0] last_grant_r;
   logic [GRANT_W-1:0] last_grant_nx_s;
   logic [GRANT_W-1:0] grant_id_r;
   logic [GRANT_W-1:0] grant_id_nx_s;
   logic [CNT_W-1:0]   beat_cnt_r;
   logic [CNT_W-1:0]   beat_cnt_nx_s;
   logic               pick_any_s;
   logic [GRANT_W-1:0] pick_idx_s;
   logic               transfer_s;
   logic [NUM_REQ-1:0] ready_s;
   logic               wr_en_s;
   logic [DATA_W-1:0]  wr_data_s;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .GRANT_W (GRANT_W)
   ) u_rr_pick (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .any        (pick_any_s),
      .grant      (pick_idx_s)
   );

   // State, grant and beat counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_W'(NUM_REQ - 1);
         grant_id_r   <= '0;
         beat_cnt_r   <= '0;
      end else begin
         state_r      <= state_nx_s;
         last_grant_r <= last_grant_nx_s;
         grant_id_r   <= grant_id_nx_s;
         beat_cnt_r   <= beat_cnt_nx_s;
      end
   end

   // Next-state logic and the zero-latency write path.
   always_comb begin
      state_nx_s      = state_r;
      last_grant_nx_s = last_grant_r;
      grant_id_nx_s   = grant_id_r;
      beat_cnt_nx_s   = beat_cnt_r;
      ready_s         = '0;
      transfer_s      = 1'b0;
      wr_en_s         = 1'b0;
      wr_data_s       = '0;
      case (state_r)
         IDLE: begin
            if (pick_any_s) begin
               state_nx_s      = BURST;
               grant_id_nx_s   = pick_idx_s;
               last_grant_nx_s = pick_idx_s;
               beat_cnt_nx_s   = '0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         BURST: begin
            ready_s[grant_id_r] = !fifo_full;
            transfer_s          = req_valid[grant_id_r] & !fifo_full;
            if (transfer_s) begin
               wr_en_s       = 1'b1;
               wr_data_s     = req_data[int'(grant_id_r)*DATA_W +: DATA_W];
               beat_cnt_nx_s = beat_cnt_r + CNT_W'(1);
               if (req_last[grant_id_r] || (beat_cnt_r == CNT_W'(MAX_BURST - 1))) begin
                  state_nx_s = IDLE;
               end else begin
                  state_nx_s = BURST;
               end
            end else begin
               // Stalled by full FIFO or a gap in the owner's valid: hold the grant.
               state_nx_s = BURST;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Reset suppresses any write that the pre-reset state would otherwise issue.
   assign req_ready    = ready_s & {NUM_REQ{!rst}};
   assign fifo_wr_en   = wr_en_s & !rst;
   assign fifo_wr_data = rst ? '0 : wr_data_s;
   assign grant_id     = grant_id_r;
   assign busy         = (state_r == BURST);

endmodule
